alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Pipeline register directly upstream of the ALU.
- Captures decoded operands and control from the decode stage and resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Presents registered src_A, src_B and ALU_control to the ALU.
- Single-entry valid/ready stage with stall and flush, so the ALU and downstream stages can back-pressure decode.

Parameters:
DATA_WIDTH, 32, width of operands, immediate and results
REG_ADDR_WIDTH, 5, width of register addresses

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  decode presents a valid instruction
in_ready  output  1  stage can accept this cycle
rs1_addr  input  REG_ADDR_WIDTH  source register 1 address
rs2_addr  input  REG_ADDR_WIDTH  source register 2 address
rd_addr  input  REG_ADDR_WIDTH  destination register address
rs1_data  input  DATA_WIDTH  register file read data 1
rs2_data  input  DATA_WIDTH  register file read data 2
immediate  input  DATA_WIDTH  sign-extended immediate
ALU_src  input  1  1: src_B takes the immediate; 0: src_B takes forwarded rs2
ALU_control_in  input  3  ALU operation code, passed through unchanged
reg_write_in  input  1  instruction writes rd
exmem_reg_write  input  1  EX/MEM stage will write its rd
exmem_rd  input  REG_ADDR_WIDTH  EX/MEM destination
exmem_result  input  DATA_WIDTH  EX/MEM ALU result
memwb_reg_write  input  1  MEM/WB stage will write its rd
memwb_rd  input  REG_ADDR_WIDTH  MEM/WB destination
memwb_result  input  DATA_WIDTH  MEM/WB write-back value
flush  input  1  discard held and incoming instruction
out_valid  output  1  src_A/src_B/ALU_control valid
out_ready  input  1  ALU/EX stage consumes this cycle
src_A  output  DATA_WIDTH  ALU operand A
src_B  output  DATA_WIDTH  ALU operand B
ALU_control  output  3  ALU operation code
rd_out  output  REG_ADDR_WIDTH  destination, passed downstream
reg_write_out  output  1  write enable, passed downstream
store_data  output  DATA_WIDTH  forwarded rs2 value, for stores

Behaviour:
- Reset, synchronous, active-high:
  - out_valid = 0.
  - src_A, src_B, store_data = 0.
  - ALU_control = 3'b000, rd_out = 0, reg_write_out = 0.
  - Reset overrides flush and any handshake in the same cycle.
- in_ready = !out_valid || out_ready || flush. It is combinational with no dependence on in_valid.
- Accept: in_valid && in_ready && !flush. On the next edge all outputs load and out_valid = 1. Latency is one cycle from accept to out_valid.
- Consume: out_valid && out_ready with no simultaneous accept. On the next edge out_valid = 0; data outputs hold their last values.
- Simultaneous consume and accept in one cycle: new data loads and out_valid stays 1, giving full throughput of one instruction per cycle.
- Stall: out_valid && !out_ready. Every output is held bit-stable and in_ready = 0.
- Flush:
  - On the next edge out_valid = 0.
  - The instruction presented that cycle is consumed (in_ready = 1) and discarded.
  - The held entry is dropped even if out_ready = 0.
  - Data outputs are don't-care while out_valid = 0, but must not be X after reset.
- Forwarding, evaluated combinationally on the input side and captured at accept:
  - fwd_1 = exmem_result if exmem_reg_write && exmem_rd == rs1_addr && exmem_rd != 0.
  - Else fwd_1 = memwb_result if memwb_reg_write && memwb_rd == rs1_addr && memwb_rd != 0.
  - Else fwd_1 = rs1_data.
  - fwd_2 is resolved identically using rs2_addr and rs2_data.
  - EX/MEM has priority over MEM/WB.
  - Register 0 is never forwarded.
- Operand selection:
  - src_A = fwd_1.
  - src_B = ALU_src ? immediate : fwd_2.
  - store_data = fwd_2 always.
- No arithmetic is performed. All paths are DATA_WIDTH wide with no truncation.

Optional Feature:
OPERAND_FORWARDING_EN
- Defined: forwarding exactly as specified above.
- Undefined:
  - fwd_1 = rs1_data and fwd_2 = rs2_data.
  - The exmem_* and memwb_* inputs remain on the port list but are ignored.
  - Handshake and timing are identical in both builds.

Test Plan:
1. Reset mid-stall:
   - Stimulus: hold out_valid = 1 with out_ready = 0, then assert reset for 1 cycle.
   - Response: out_valid = 0, src_A = 0, src_B = 0, ALU_control = 000 next edge.
2. Pass-through:
   - Stimulus: rs1_data = 32'h00000001, rs2_data = 32'h00000001, ALU_src = 0, ALU_control_in = 3'b001, in_valid = 1, out_ready = 1, no forwarding.
   - Response: next edge out_valid = 1, src_A = 1, src_B = 1, ALU_control = 001.
3. Forward priority:
   - Stimulus: rs1_addr = 5, exmem_rd = 5, exmem_result = 32'hAAAA0000, memwb_rd = 5, memwb_result = 32'h0000BBBB, both write enables = 1.
   - Response: src_A = 32'hAAAA0000.
   - Repeat with exmem_reg_write = 0: src_A = 32'h0000BBBB.
   - Repeat with rs1_addr = 0 and both rd = 0: src_A = rs1_data.
4. Immediate select:
   - Stimulus: ALU_src = 1, immediate = 32'hFFFFFFFC, rs2 forwarded from EX/MEM = 32'h12345678.
   - Response: src_B = 32'hFFFFFFFC, store_data = 32'h12345678.
5. Stall then drain:
   - Stimulus: accept A = 7, hold out_ready = 0 for 3 cycles while in_valid = 1 with A = 9, then raise out_ready.
   - Response:
     - While stalled: src_A stays 7 and in_ready = 0.
     - First cycle with out_ready = 1: in_ready = 1 and the A = 9 instruction is accepted.
     - Next edge: src_A = 9, out_valid = 1.
6. Flush during stall:
   - Stimulus: out_valid = 1, out_ready = 0, in_valid = 1, flush = 1 for one cycle.
   - Response: in_ready = 1 that cycle, out_valid = 0 next edge, and the incoming instruction never appears on the outputs.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Purpose: single-entry pipeline register ahead of the ALU; resolves EX/MEM and MEM/WB forwarding
//          (forwarding compiled in only when OPERAND_FORWARDING_EN is defined).
// Latency: one cycle from accept to out_valid; a consume and an accept in the same cycle sustain one instruction per cycle.
// Backpressure: in_ready = !out_valid || out_ready || flush; a stalled entry holds every output bit-stable.
module alu_operand_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]     rs1_data,
    input  logic [DATA_WIDTH-1:0]     rs2_data,
    input  logic [DATA_WIDTH-1:0]     immediate,
    input  logic                      ALU_src,
    input  logic [2:0]                ALU_control_in,
    input  logic                      reg_write_in,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     src_A,
    output logic [DATA_WIDTH-1:0]     src_B,
    output logic [2:0]                ALU_control,
    output logic [REG_ADDR_WIDTH-1:0] rd_out,
    output logic                      reg_write_out,
    output logic [DATA_WIDTH-1:0]     store_data
);

    logic [DATA_WIDTH-1:0]     fwd_1;
    logic [DATA_WIDTH-1:0]     fwd_2;
    logic                      accept;

    logic                      valid_q, valid_d;
    logic [DATA_WIDTH-1:0]     src_a_q, src_a_d;
    logic [DATA_WIDTH-1:0]     src_b_q, src_b_d;
    logic [DATA_WIDTH-1:0]     store_data_q, store_data_d;
    logic [2:0]                alu_control_q, alu_control_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      reg_write_q, reg_write_d;

`ifdef OPERAND_FORWARDING_EN
    // Operand bypass: youngest producer (EX/MEM) wins, register 0 is hard-wired and never bypassed.
    always_comb begin
        fwd_1 = rs1_data;
        fwd_2 = rs2_data;
        if (exmem_reg_write && (exmem_rd == rs1_addr) && (exmem_rd != '0))
            fwd_1 = exmem_result;
        else if (memwb_reg_write && (memwb_rd == rs1_addr) && (memwb_rd != '0))
            fwd_1 = memwb_result;
        if (exmem_reg_write && (exmem_rd == rs2_addr) && (exmem_rd != '0))
            fwd_2 = exmem_result;
        else if (memwb_reg_write && (memwb_rd == rs2_addr) && (memwb_rd != '0))
            fwd_2 = memwb_result;
    end
`else
    // Without bypassing the register file data is used as-is; the bypass ports stay but are ignored.
    always_comb begin
        fwd_1 = rs1_data;
        fwd_2 = rs2_data;
    end

    logic unused_fwd_ports;
    assign unused_fwd_ports = ^{exmem_reg_write, exmem_rd, exmem_result,
                                memwb_reg_write, memwb_rd, memwb_result};
`endif

    assign in_ready = !valid_q || out_ready || flush;
    assign accept   = in_valid && in_ready && !flush;

    // Next-state: flush drops everything, accept loads, consume clears valid; data holds otherwise.
    always_comb begin
        valid_d       = valid_q;
        src_a_d       = src_a_q;
        src_b_d       = src_b_q;
        store_data_d  = store_data_q;
        alu_control_d = alu_control_q;
        rd_d          = rd_q;
        reg_write_d   = reg_write_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d       = 1'b1;
            src_a_d       = fwd_1;
            src_b_d       = ALU_src ? immediate : fwd_2;
            store_data_d  = fwd_2;
            alu_control_d = ALU_control_in;
            rd_d          = rd_addr;
            reg_write_d   = reg_write_in;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Stage register with synchronous reset taking precedence over flush and handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q       <= 1'b0;
            src_a_q       <= '0;
            src_b_q       <= '0;
            store_data_q  <= '0;
            alu_control_q <= 3'b000;
            rd_q          <= '0;
            reg_write_q   <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            src_a_q       <= src_a_d;
            src_b_q       <= src_b_d;
            store_data_q  <= store_data_d;
            alu_control_q <= alu_control_d;
            rd_q          <= rd_d;
            reg_write_q   <= reg_write_d;
        end
    end

    assign out_valid     = valid_q;
    assign src_A         = src_a_q;
    assign src_B         = src_b_q;
    assign store_data    = store_data_q;
    assign ALU_control   = alu_control_q;
    assign rd_out        = rd_q;
    assign reg_write_out = reg_write_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, pass-through, forwarding priority,
// immediate select, stall/drain, flush during stall, consume-only and reset mid-stall.
// Expected forwarded values follow OPERAND_FORWARDING_EN so either build can be checked.
module tb_alu_operand_stage;

`ifdef OPERAND_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_data, rs2_data, immediate;
    logic        ALU_src;
    logic [2:0]  ALU_control_in;
    logic        reg_write_in;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] src_A, src_B, store_data;
    logic [2:0]  ALU_control;
    logic [4:0]  rd_out;
    logic        reg_write_out;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_operand_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .immediate(immediate),
        .ALU_src(ALU_src), .ALU_control_in(ALU_control_in), .reg_write_in(reg_write_in),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .src_A(src_A), .src_B(src_B), .ALU_control(ALU_control),
        .rd_out(rd_out), .reg_write_out(reg_write_out), .store_data(store_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the settle point just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
        rs1_data = '0; rs2_data = '0; immediate = '0;
        ALU_src = 1'b0; ALU_control_in = 3'b000; reg_write_in = 1'b0;
        exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
        step(); step();
        @(negedge clock); reset = 1'b0; #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_src_A", src_A, 32'd0);
        chk("rst_src_B", src_B, 32'd0);
        chk("rst_store", store_data, 32'd0);
        chk("rst_ctrl", 32'(ALU_control), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Pass-through, no forwarding.
        @(negedge clock);
        rs1_addr = 5'd1; rs2_addr = 5'd2; rd_addr = 5'd3;
        rs1_data = 32'h1; rs2_data = 32'h1; ALU_src = 1'b0;
        ALU_control_in = 3'b001; reg_write_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("pt_out_valid", 32'(out_valid), 32'd1);
        chk("pt_src_A", src_A, 32'h1);
        chk("pt_src_B", src_B, 32'h1);
        chk("pt_ctrl", 32'(ALU_control), 32'd1);
        chk("pt_rd_out", 32'(rd_out), 32'd3);
        chk("pt_reg_write", 32'(reg_write_out), 32'd1);
        chk("pt_store", store_data, 32'h1);

        // Forward priority on rs1 (back-to-back accepts with out_ready high).
        @(negedge clock);
        rs1_addr = 5'd5; rs1_data = 32'h11111111; ALU_control_in = 3'b010;
        exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hAAAA0000;
        memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h0000BBBB;
        step();
        chk("fwd_exmem_prio", src_A, FWD ? 32'hAAAA0000 : 32'h11111111);
        chk("fwd_src_B_untouched", src_B, 32'h1);
        chk("fwd_ctrl", 32'(ALU_control), 32'd2);
        @(negedge clock); exmem_reg_write = 1'b0;
        step();
        chk("fwd_memwb", src_A, FWD ? 32'h0000BBBB : 32'h11111111);
        @(negedge clock);
        exmem_reg_write = 1'b1; rs1_addr = 5'd0; exmem_rd = 5'd0; memwb_rd = 5'd0;
        step();
        chk("fwd_r0_never", src_A, 32'h11111111);

        // Immediate select with rs2 forwarded from EX/MEM.
        @(negedge clock);
        ALU_src = 1'b1; immediate = 32'hFFFFFFFC;
        rs2_addr = 5'd6; rs2_data = 32'hDEADBEEF;
        exmem_reg_write = 1'b1; exmem_rd = 5'd6; exmem_result = 32'h12345678;
        memwb_reg_write = 1'b0;
        step();
        chk("imm_src_B", src_B, 32'hFFFFFFFC);
        chk("imm_store", store_data, FWD ? 32'h12345678 : 32'hDEADBEEF);

        // Stall then drain.
        @(negedge clock);
        exmem_reg_write = 1'b0; ALU_src = 1'b0; rs1_data = 32'd7;
        step();
        chk("stall_load_A", src_A, 32'd7);
        @(negedge clock); out_ready = 1'b0; rs1_data = 32'd9; #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold_A", src_A, 32'd7);
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
            chk("stall_hold_store", store_data, 32'hDEADBEEF);
            chk("stall_in_ready_hold", 32'(in_ready), 32'd0);
        end
        @(negedge clock); out_ready = 1'b1; #1;
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("drain_src_A", src_A, 32'd9);
        chk("drain_valid", 32'(out_valid), 32'd1);

        // Flush during stall: incoming instruction is consumed and discarded.
        @(negedge clock);
        out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; rs1_data = 32'h55; #1;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("flush_valid", 32'(out_valid), 32'd0);
        @(negedge clock); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("flush_stays_invalid", 32'(out_valid), 32'd0);
        chk("flush_not_loaded", 32'(src_A != 32'h55), 32'd1);

        // Accept then consume-only: valid drops, data holds.
        @(negedge clock); in_valid = 1'b1; rs1_data = 32'h21;
        step();
        chk("cons_load", src_A, 32'h21);
        @(negedge clock); in_valid = 1'b0;
        step();
        chk("cons_valid", 32'(out_valid), 32'd0);
        chk("cons_hold_A", src_A, 32'h21);

        // Reset mid-stall with a pending input.
        @(negedge clock); in_valid = 1'b1; out_ready = 1'b0; rs1_data = 32'h33;
        step();
        chk("rstm_stalled", 32'(out_valid), 32'd1);
        @(negedge clock); reset = 1'b1;
        step();
        chk("rstm_valid", 32'(out_valid), 32'd0);
        chk("rstm_src_A", src_A, 32'd0);
        chk("rstm_src_B", src_B, 32'd0);
        chk("rstm_ctrl", 32'(ALU_control), 32'd0);
        chk("rstm_rd_out", 32'(rd_out), 32'd0);
        chk("rstm_reg_write", 32'(reg_write_out), 32'd0);
        @(negedge clock); reset = 1'b0; in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
